// File: rtl/ila_pattern_player.sv
// ila_pattern_player: software-loaded stimulus buffer.
// Software writes up to DEPTH 64-bit samples as pairs of 32-bit words, sets LEN
// (and optionally LOOP), then issues START. The samples are replayed on a
// valid/ready stream, and trigger_out pulses with the first beat so that a
// capture block can be armed on the very same run.
module ila_pattern_player #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_wr_en,
    input  logic [5:0]            cfg_addr,
    input  logic [31:0]           cfg_wdata,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  trigger_out,
    output logic                  busy,
    output logic                  done,
    output logic                  write_err,
    output logic [CNT_WIDTH-1:0]  beat_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LEN_W = 5;
    localparam logic [5:0]       ADDR_LEN  = 6'h20;
    localparam logic [5:0]       ADDR_CTRL = 6'h21;
    localparam logic [5:0]       MEM_WORDS = 6'(2 * DEPTH);
    localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  loop_q, loop_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  data_valid_q, data_valid_d;
    logic                  trigger_q, trigger_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  write_err_q, write_err_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;

    logic                  wr_mem_s;
    logic                  wr_len_s;
    logic                  wr_ctrl_s;
    logic                  start_s;
    logic                  abort_s;
    logic [IDX_W-1:0]      mem_idx_s;
    logic [LEN_W-1:0]      len_clamp_s;
    logic                  last_s;
    logic                  xfer_s;

    // Decode the config write into mem / LEN / CTRL strobes and the clamped LEN value.
    always_comb begin
        wr_mem_s    = cfg_wr_en && (cfg_addr < MEM_WORDS);
        wr_len_s    = cfg_wr_en && (cfg_addr == ADDR_LEN);
        wr_ctrl_s   = cfg_wr_en && (cfg_addr == ADDR_CTRL);
        start_s     = wr_ctrl_s && cfg_wdata[0];
        abort_s     = wr_ctrl_s && cfg_wdata[2];
        mem_idx_s   = IDX_W'(cfg_addr >> 1);
        if (cfg_wdata[LEN_W-1:0] > LEN_MAX) begin
            len_clamp_s = LEN_MAX;
        end else begin
            len_clamp_s = cfg_wdata[LEN_W-1:0];
        end
        last_s      = (LEN_W'(idx_q) == (len_q - 5'd1));
        xfer_s      = data_valid_q && data_ready;
    end

    // Next-state logic: config writes, run start/abort and stream sequencing.
    always_comb begin
        state_d      = state_q;
        mem_d        = mem_q;
        len_d        = len_q;
        loop_d       = loop_q;
        idx_d        = idx_q;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        trigger_d    = 1'b0;
        done_d       = done_q;
        write_err_d  = write_err_q;
        beat_cnt_d   = beat_cnt_q;

        // LOOP is stored on every CTRL write, even mid-run; it is consulted at the wrap.
        if (wr_ctrl_s) begin
            loop_d = cfg_wdata[1];
        end else begin
            loop_d = loop_q;
        end

        if (abort_s) begin
            // ABORT wins over a START carried in the same write.
            state_d      = ST_IDLE;
            data_valid_d = 1'b0;
            done_d       = 1'b0;
        end else if (state_q == ST_PLAY) begin
            // Sample memory and LEN are frozen for the run; touching them is an error.
            if (wr_mem_s || wr_len_s || start_s) begin
                write_err_d = 1'b1;
            end else begin
                write_err_d = write_err_q;
            end
            if (xfer_s) begin
                beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
                if (!last_s) begin
                    idx_d      = idx_q + IDX_W'(1);
                    data_out_d = mem_q[idx_q + IDX_W'(1)];
                end else if (loop_q) begin
                    idx_d      = '0;
                    data_out_d = mem_q[0];
                end else begin
                    state_d      = ST_DONE;
                    data_valid_d = 1'b0;
                    done_d       = 1'b1;
                end
            end else begin
                // Stalled: hold the presented sample until it is accepted.
                data_out_d = data_out_q;
            end
        end else begin
            // IDLE and DONE accept configuration and START alike.
            if (wr_mem_s) begin
                if (cfg_addr[0]) begin
                    mem_d[mem_idx_s][31:0] = cfg_wdata;
                end else begin
                    mem_d[mem_idx_s][DATA_WIDTH-1 -: 32] = cfg_wdata;
                end
            end else begin
                mem_d = mem_q;
            end
            if (wr_len_s) begin
                len_d = len_clamp_s;
            end else begin
                len_d = len_q;
            end
            // A START with LEN == 0 leaves state and flags untouched.
            if (start_s && (len_q != 5'd0)) begin
                state_d      = ST_PLAY;
                idx_d        = '0;
                data_out_d   = mem_q[0];
                data_valid_d = 1'b1;
                trigger_d    = 1'b1;
                done_d       = 1'b0;
                write_err_d  = 1'b0;
                beat_cnt_d   = '0;
            end else begin
                state_d = state_q;
            end
        end

        busy_d = (state_d == ST_PLAY);
    end

    // State and output registers with synchronous reset; reset aborts any run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            len_q        <= LEN_MAX;
            loop_q       <= 1'b0;
            idx_q        <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            trigger_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            write_err_q  <= 1'b0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            len_q        <= len_d;
            loop_q       <= loop_d;
            idx_q        <= idx_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            trigger_q    <= trigger_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            write_err_q  <= write_err_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign trigger_out = trigger_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign write_err   = write_err_q;
    assign beat_cnt    = beat_cnt_q;

endmodule

// File: tb/tb_ila_pattern_player.sv
// Testbench for ila_pattern_player: directed scenarios plus randomized runs,
// with every streamed beat compared against a sample-array reference model.
module tb_ila_pattern_player;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr_en;
    logic [5:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [63:0] data_out;
    logic        data_valid;
    logic        data_ready;
    logic        trigger_out;
    logic        busy;
    logic        done;
    logic        write_err;
    logic [15:0] beat_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: sample contents, effective length, loop flag.
    logic [63:0] mem_m [16];
    int          len_m;
    logic [63:0] got [$];
    int          rdy_pat [$];

    ila_pattern_player #(.DATA_WIDTH(64), .DEPTH(16), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .data_out(data_out), .data_valid(data_valid),
        .data_ready(data_ready), .trigger_out(trigger_out), .busy(busy),
        .done(done), .write_err(write_err), .beat_cnt(beat_cnt)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs == exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Config write; entered and left on a falling edge.
    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        cfg_wr_en = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_wr_en = 1'b0;
    endtask

    task automatic mw(input int i, input logic [63:0] v);
        wr(6'(2 * i), v[63:32]);
        wr(6'(2 * i + 1), v[31:0]);
        mem_m[i] = v;
    endtask

    task automatic set_len(input int v);
        wr(6'h20, 32'(v));
        len_m = ((v % 32) > 16) ? 16 : (v % 32);
    endtask

    // Drive data_ready and record accepted beats until the run ends or stop_beats is reached.
    task automatic collect(input logic trig_exp, input int stop_beats, input logic rnd);
        int          cyc;
        logic        stalled;
        logic        r;
        logic [63:0] held;
        cyc = 0;
        stalled = 1'b0;
        held = '0;
        got.delete();
        forever begin
            if (cyc == 0) chkb("first_valid", data_valid, 1'b1);
            if (!data_valid) break;
            chkb("trigger", trigger_out, (cyc == 0) && trig_exp);
            chkb("busy_play", busy, 1'b1);
            if (stalled) chk("stall_hold", data_out, held);
            if (rdy_pat.size() > 0) r = (rdy_pat.pop_front() != 0);
            else if (rnd) r = ($urandom_range(0, 1) == 1);
            else r = 1'b1;
            data_ready = r;
            if (r) got.push_back(data_out);
            held = data_out;
            stalled = !r;
            @(negedge clk);
            cyc++;
            if (got.size() == stop_beats) break;
            if (cyc > 400) begin
                chki("timeout", cyc, 0);
                break;
            end
        end
        data_ready = 1'b0;
    endtask

    // Compare recorded beats against the model: beat k carries sample k mod LEN.
    task automatic check_stream(input string tag, input int n);
        chki({tag, "_count"}, got.size(), n);
        for (int k = 0; k < got.size() && k < n; k++) begin
            chk($sformatf("%s_beat%0d", tag, k), got[k], mem_m[k % len_m]);
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_wr_en = 1'b0;
        cfg_addr = '0;
        cfg_wdata = '0;
        data_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        len_m = 16;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_data", data_out, 64'h0);
        chkb("rst_valid", data_valid, 1'b0);
        chkb("rst_trig", trigger_out, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_done", done, 1'b0);
        chkb("rst_werr", write_err, 1'b0);
        chki("rst_cnt", int'(beat_cnt), 0);

        // 1: four samples, always ready
        mw(0, 64'h1111_1111_1111_1111);
        mw(1, 64'h2222_2222_2222_2222);
        mw(2, 64'h3333_3333_3333_3333);
        mw(3, 64'h4444_4444_4444_4444);
        set_len(4);
        wr(6'h21, 32'h1);
        collect(1'b1, 1000, 1'b0);
        check_stream("t1", 4);
        chkb("t1_done", done, 1'b1);
        chkb("t1_busy", busy, 1'b0);
        chki("t1_cnt", int'(beat_cnt), 4);

        // 2: backpressure pattern, restarted from DONE
        rdy_pat = '{1, 0, 0, 1, 0, 1, 1};
        wr(6'h21, 32'h1);
        collect(1'b1, 1000, 1'b0);
        check_stream("t2", 4);
        chki("t2_cnt", int'(beat_cnt), 4);

        // 3: LEN=3 looping, ABORT after 7 beats
        set_len(3);
        wr(6'h21, 32'h3);
        collect(1'b1, 7, 1'b0);
        check_stream("t3", 7);
        wr(6'h21, 32'h4);
        chkb("t3_valid", data_valid, 1'b0);
        chkb("t3_busy", busy, 1'b0);
        chkb("t3_done", done, 1'b0);
        chki("t3_cnt", int'(beat_cnt), 7);

        // 4: illegal writes during a stalled run
        set_len(4);
        wr(6'h21, 32'h1);
        chkb("t4_trig", trigger_out, 1'b1);
        wr(6'h02, 32'hDEAD_BEEF);
        wr(6'h20, 32'h2);
        wr(6'h21, 32'h1);
        chkb("t4_werr", write_err, 1'b1);
        chkb("t4_busy", busy, 1'b1);
        chkb("t4_trig2", trigger_out, 1'b0);
        chk("t4_hold", data_out, mem_m[0]);
        collect(1'b0, 1000, 1'b0);
        check_stream("t4", 4);
        chkb("t4_werr_kept", write_err, 1'b1);
        wr(6'h21, 32'h1);
        chkb("t4_werr_clr", write_err, 1'b0);
        collect(1'b1, 1000, 1'b1);
        check_stream("t4b", 4);

        // 5: reset in the middle of an 8-beat run
        for (int i = 0; i < 8; i++) mw(i, {$urandom, $urandom});
        set_len(8);
        wr(6'h21, 32'h1);
        collect(1'b1, 2, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_data", data_out, 64'h0);
        chkb("t5_valid", data_valid, 1'b0);
        chkb("t5_busy", busy, 1'b0);
        chkb("t5_done", done, 1'b0);
        chkb("t5_werr", write_err, 1'b0);
        chki("t5_cnt", int'(beat_cnt), 0);
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        len_m = 16;
        wr(6'h21, 32'h1);
        collect(1'b1, 1000, 1'b1);
        check_stream("t5", 16);

        // 6: LEN=0 START is ignored; LEN=20 clamps to 16
        set_len(0);
        wr(6'h21, 32'h1);
        for (int i = 0; i < 3; i++) begin
            chkb("t6_valid", data_valid, 1'b0);
            chkb("t6_busy", busy, 1'b0);
            @(negedge clk);
        end
        chkb("t6_done", done, 1'b1);
        chki("t6_cnt", int'(beat_cnt), 16);
        for (int i = 0; i < 16; i++) mw(i, {$urandom, $urandom});
        set_len(20);
        wr(6'h21, 32'h1);
        collect(1'b1, 1000, 1'b1);
        check_stream("t6", 16);
        chki("t6_cnt2", int'(beat_cnt), 16);

        // Randomized runs: random length, contents and backpressure
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 1) == 1) mw(i, {$urandom, $urandom});
            end
            set_len(int'($urandom_range(1, 16)));
            wr(6'h21, 32'h1);
            collect(1'b1, 1000, 1'b1);
            check_stream($sformatf("rnd%0d", it), len_m);
            chki("rnd_cnt", int'(beat_cnt), len_m);
            chkb("rnd_done", done, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
